write_data_router: RTL and testbench

WRITE_DATA_ROUTER -- requirements
Module: write_data_router

---
 rtl/write_data_router.sv | 125 ++++++++++++
 tb/tb_write_data_router.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/write_data_router.sv
// write_data_router
//   Routes the W channel of the master at the head of the write-address
//   queue onto the single slave W channel, one burst at a time.
//
//   Ports
//     ACLK, ARESET              clock, asynchronous active-high reset
//     Write_Data_HandShake_En   queue non-empty (level)
//     Write_Data_Master         master index at the queue head
//     Write_Data_Finsh          one-cycle pulse, burst done; pops the queue
//     M_W*                      flattened per-master W channels (slice i = master i)
//     S_W*                      slave W channel
//     Busy                      high while a burst is being forwarded
//     Protocol_Error            sticky: bad master index or beat limit overrun
module write_data_router #(
   parameter int Masters_Num = 2,
   parameter int ID_Size     = $clog2(Masters_Num),
   parameter int Data_Width  = 32,
   parameter int Max_Beats   = 256
) (
   input  logic                             ACLK,
   input  logic                             ARESET,
   input  logic                             Write_Data_HandShake_En,
   input  logic [ID_Size-1:0]               Write_Data_Master,
   output logic                             Write_Data_Finsh,
   input  logic [Masters_Num*Data_Width-1:0]     M_WDATA,
   input  logic [Masters_Num*(Data_Width/8)-1:0] M_WSTRB,
   input  logic [Masters_Num-1:0]           M_WLAST,
   input  logic [Masters_Num-1:0]           M_WVALID,
   output logic [Masters_Num-1:0]           M_WREADY,
   output logic [Data_Width-1:0]            S_WDATA,
   output logic [Data_Width/8-1:0]          S_WSTRB,
   output logic                             S_WLAST,
   output logic                             S_WVALID,
   input  logic                             S_WREADY,
   output logic                             Busy,
   output logic                             Protocol_Error
);

   localparam int Strb_Width = Data_Width/8;
   localparam int Cnt_Width  = $clog2(Max_Beats) + 1;

   typedef enum logic [1:0] {IDLE, ACTIVE, DRAIN} state_t;

   state_t                 state, state_nxt;
   logic [ID_Size-1:0]     sel;
   logic [Cnt_Width-1:0]   beat_cnt;

   logic                   sel_ok;
   logic [Data_Width-1:0]  sel_wdata;
   logic [Strb_Width-1:0]  sel_wstrb;
   logic                   sel_wlast, sel_wvalid;
   logic                   active, route, beat, at_limit, burst_end, limit_err;

   // Slice select. sel_ok is low when the queued index names no master
   // (possible when Masters_Num is not a power of two).
   always_comb begin
      sel_ok     = 1'b0;
      sel_wdata  = '0;
      sel_wstrb  = '0;
      sel_wlast  = 1'b0;
      sel_wvalid = 1'b0;
      for (int i = 0; i < Masters_Num; i++) begin
         if (int'(sel) == i) begin
            sel_ok     = 1'b1;
            sel_wdata  = M_WDATA[i*Data_Width +: Data_Width];
            sel_wstrb  = M_WSTRB[i*Strb_Width +: Strb_Width];
            sel_wlast  = M_WLAST[i];
            sel_wvalid = M_WVALID[i];
         end
      end
   end

   assign active   = (state == ACTIVE);
   assign route    = active & sel_ok;
   // The beat that would bring the count to Max_Beats is the last one we take.
   assign at_limit = (beat_cnt == Cnt_Width'(Max_Beats - 1));

   assign S_WVALID = route & sel_wvalid;
   assign S_WDATA  = route ? sel_wdata : '0;
   assign S_WSTRB  = route ? sel_wstrb : '0;
   assign S_WLAST  = route & (sel_wlast | at_limit);
   assign Busy     = active;

   assign beat      = S_WVALID & S_WREADY;
   assign burst_end = beat & (sel_wlast | at_limit);
   assign limit_err = beat & at_limit & ~sel_wlast;

   always_comb begin
      M_WREADY = '0;
      for (int i = 0; i < Masters_Num; i++)
         M_WREADY[i] = route & (int'(sel) == i) & S_WREADY;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (Write_Data_HandShake_En) state_nxt = ACTIVE;
         ACTIVE:  if (!sel_ok || burst_end)    state_nxt = DRAIN;
         DRAIN:   state_nxt = IDLE;  // one cycle for the queue head to advance
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
         state            <= IDLE;
         sel              <= '0;
         beat_cnt         <= '0;
         Write_Data_Finsh <= 1'b0;
         Protocol_Error   <= 1'b0;
      end else begin
         state            <= state_nxt;
         Write_Data_Finsh <= active & (~sel_ok | burst_end);
         if (state == IDLE && Write_Data_HandShake_En) begin
            sel      <= Write_Data_Master;
            beat_cnt <= '0;
         end else if (beat && beat_cnt != Cnt_Width'(Max_Beats)) begin
            beat_cnt <= beat_cnt + Cnt_Width'(1);
         end
         if (active & (~sel_ok | limit_err))
            Protocol_Error <= 1'b1;
      end
   end

endmodule

// File: tb/tb_write_data_router.sv
// Scoreboard bench for write_data_router (3 masters, 8-beat limit).
// Stimulus pushes expected slave beats / finish pulses into queues; the
// monitor pops and compares at each falling edge.
module tb_write_data_router;

   localparam int NM = 3;
   localparam int IW = 2;
   localparam int DW = 32;
   localparam int SW = 4;
   localparam int MB = 8;

   typedef struct packed {
      logic [DW-1:0] d;
      logic [SW-1:0] s;
      logic          l;
   } beat_t;

   logic              ACLK = 1'b0;
   logic              ARESET;
   logic              En;
   logic [IW-1:0]     Master;
   logic              Finsh;
   logic [NM*DW-1:0]  M_WDATA;
   logic [NM*SW-1:0]  M_WSTRB;
   logic [NM-1:0]     M_WLAST, M_WVALID, M_WREADY;
   logic [DW-1:0]     S_WDATA;
   logic [SW-1:0]     S_WSTRB;
   logic              S_WLAST, S_WVALID, S_WREADY;
   logic              Busy, Perr;

   write_data_router #(.Masters_Num(NM), .ID_Size(IW), .Data_Width(DW), .Max_Beats(MB)) dut (
      .ACLK(ACLK), .ARESET(ARESET),
      .Write_Data_HandShake_En(En), .Write_Data_Master(Master), .Write_Data_Finsh(Finsh),
      .M_WDATA(M_WDATA), .M_WSTRB(M_WSTRB), .M_WLAST(M_WLAST), .M_WVALID(M_WVALID),
      .M_WREADY(M_WREADY),
      .S_WDATA(S_WDATA), .S_WSTRB(S_WSTRB), .S_WLAST(S_WLAST), .S_WVALID(S_WVALID),
      .S_WREADY(S_WREADY), .Busy(Busy), .Protocol_Error(Perr)
   );

   always #5 ACLK = ~ACLK;

   beat_t mq[NM][$];   // beats each master still has to send
   int    hq[$];       // write-address queue (master indices)
   beat_t sb[$];       // expected slave beats, in order
   int    exp_fin = 0;
   bit    tog = 1'b0;
   int    n_vec = 0, n_err = 0;

   task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic fail(string nm);
      n_vec++;
      n_err++;
      $display("FAIL %s: event occurred/expired when it should not", nm);
   endtask

   function automatic beat_t mk(int m, int k, bit last);
      beat_t b;
      b.d = 32'hD000_0000 + 32'(m) * 32'h0100_0000 + 32'(k) * 32'h0000_0101;
      b.s = 4'(k + 1);
      b.l = last;
      return b;
   endfunction

   task automatic drive();
      for (int i = 0; i < NM; i++) begin
         M_WVALID[i] = (mq[i].size() > 0);
         M_WDATA[i*DW +: DW] = M_WVALID[i] ? mq[i][0].d : '0;
         M_WSTRB[i*SW +: SW] = M_WVALID[i] ? mq[i][0].s : '0;
         M_WLAST[i]          = M_WVALID[i] ? mq[i][0].l : 1'b0;
      end
      En     = (hq.size() > 0);
      Master = En ? IW'(hq[0]) : '0;
   endtask

   task automatic add_beats(int m, int n, int wlast_at);
      for (int k = 0; k < n; k++) mq[m].push_back(mk(m, k, k == wlast_at));
   endtask

   task automatic expect_beats(int m, int n, int last_at);
      for (int k = 0; k < n; k++) sb.push_back(mk(m, k, k == last_at));
   endtask

   task automatic queue_burst(int m, int fin);
      hq.push_back(m);
      exp_fin += fin;
   endtask

   task automatic at_edge();
      @(posedge ACLK);
      #2;
   endtask

   task automatic wait_done(string nm);
      bit ok = 1'b0;
      for (int c = 0; c < 300; c++) begin
         at_edge();
         if (hq.size() == 0 && sb.size() == 0 && exp_fin == 0) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) fail(nm);
      repeat (2) at_edge();
   endtask

   // Master/queue BFM: handshakes sampled on the falling edge, state advanced
   // just after the rising edge.
   initial begin
      bit [NM-1:0] fire;
      bit fin;
      forever begin
         @(negedge ACLK);
         fire = M_WVALID & M_WREADY;
         fin  = Finsh;
         @(posedge ACLK);
         #1;
         for (int i = 0; i < NM; i++)
            if (fire[i] && mq[i].size() > 0) void'(mq[i].pop_front());
         if (fin && hq.size() > 0) void'(hq.pop_front());
         S_WREADY = tog ? ~S_WREADY : 1'b1;
         drive();
      end
   end

   // Monitor / scoreboard
   initial begin
      int cyc = 0, last_fin = -100;
      bit prev_fin = 1'b0;
      logic [NM-1:0] allowed;
      beat_t e;
      forever begin
         @(negedge ACLK);
         cyc++;
         if (ARESET) begin
            prev_fin = 1'b0;
            continue;
         end
         allowed = '0;
         if (hq.size() > 0 && hq[0] < NM) allowed[hq[0]] = 1'b1;
         chk("stray_wready", 64'(M_WREADY & ~allowed), 64'(0));
         if (!Busy) begin
            chk("idle_wready", 64'(M_WREADY), 64'(0));
            chk("idle_svalid", 64'(S_WVALID), 64'(0));
            chk("idle_sdata",  64'(S_WDATA), 64'(0));
         end
         if (S_WVALID && S_WREADY) begin
            if (sb.size() == 0) fail("unexpected_beat");
            else begin
               e = sb.pop_front();
               chk("beat_data", 64'(S_WDATA), 64'(e.d));
               chk("beat_strb", 64'(S_WSTRB), 64'(e.s));
               chk("beat_last", 64'(S_WLAST), 64'(e.l));
               chk("beat_wready", 64'(M_WREADY), 64'(allowed));
               chk("beat_busy", 64'(Busy), 64'(1));
            end
         end
         if (Finsh) begin
            if (exp_fin == 0) fail("unexpected_finsh");
            else exp_fin--;
            chk("finsh_busy", 64'(Busy), 64'(0));
            chk("finsh_width", 64'(prev_fin), 64'(0));
            chk("finsh_gap", 64'(cyc - last_fin >= 2), 64'(1));
            last_fin = cyc;
         end
         prev_fin = Finsh;
      end
   end

   initial begin
      bit ok;
      ARESET = 1'b1;
      S_WREADY = 1'b1;
      M_WDATA = '0; M_WSTRB = '0; M_WLAST = '0; M_WVALID = '0;
      En = 1'b0; Master = '0;
      repeat (2) @(posedge ACLK);
      #1;
      chk("rst_busy",   64'(Busy), 64'(0));
      chk("rst_finsh",  64'(Finsh), 64'(0));
      chk("rst_perr",   64'(Perr), 64'(0));
      chk("rst_wready", 64'(M_WREADY), 64'(0));
      chk("rst_svalid", 64'(S_WVALID), 64'(0));
      @(negedge ACLK);
      ARESET = 1'b0;

      // master 1, 4 beats, WLAST on beat 4
      at_edge();
      add_beats(1, 4, 3); expect_beats(1, 4, 3); queue_burst(1, 1); drive();
      wait_done("t_basic_timeout");
      chk("basic_perr", 64'(Perr), 64'(0));

      // toggled ready, 8 beats (exactly the limit, with WLAST); master 0 waits with WVALID up
      at_edge();
      tog = 1'b1;
      add_beats(1, 8, 7); add_beats(0, 3, 2);
      expect_beats(1, 8, 7); expect_beats(0, 3, 2);
      queue_burst(1, 1); queue_burst(0, 1); drive();
      wait_done("t_toggle_timeout");
      tog = 1'b0;
      chk("toggle_perr", 64'(Perr), 64'(0));

      // queue order 0 then 1, level held high
      at_edge();
      add_beats(0, 2, 1); add_beats(1, 2, 1);
      expect_beats(0, 2, 1); expect_beats(1, 2, 1);
      queue_burst(0, 1); queue_burst(1, 1); drive();
      wait_done("t_order_timeout");

      // nonexistent master 3, master 0 has a stray beat pending
      at_edge();
      add_beats(0, 1, 0); queue_burst(3, 1); drive();
      wait_done("t_badsel_timeout");
      chk("badsel_perr", 64'(Perr), 64'(1));
      chk("badsel_no_ack", 64'(mq[0].size()), 64'(1));
      chk("badsel_idle", 64'(Busy), 64'(0));
      mq[0].delete(); drive();

      // error flag holds until reset
      at_edge();
      chk("perr_sticky", 64'(Perr), 64'(1));
      ARESET = 1'b1;
      #1;
      chk("perr_cleared", 64'(Perr), 64'(0));
      @(negedge ACLK);
      ARESET = 1'b0;

      // beat limit: master 2 sends 10 beats without WLAST
      at_edge();
      add_beats(2, 10, -1); expect_beats(2, 8, 7); queue_burst(2, 1); drive();
      wait_done("t_limit_timeout");
      chk("limit_perr", 64'(Perr), 64'(1));
      chk("limit_left", 64'(mq[2].size()), 64'(2));
      mq[2].delete(); drive();

      // reset after beat 2 of a 4-beat burst
      at_edge();
      add_beats(1, 4, 3); expect_beats(1, 2, -1); queue_burst(1, 0); drive();
      ok = 1'b0;
      for (int c = 0; c < 50; c++) begin
         at_edge();
         if (mq[1].size() == 2) begin ok = 1'b1; break; end
      end
      if (!ok) fail("t_reset_timeout");
      ARESET = 1'b1;
      #1;
      chk("mid_rst_svalid", 64'(S_WVALID), 64'(0));
      chk("mid_rst_wready", 64'(M_WREADY), 64'(0));
      chk("mid_rst_sdata",  64'(S_WDATA), 64'(0));
      chk("mid_rst_slast",  64'(S_WLAST), 64'(0));
      chk("mid_rst_busy",   64'(Busy), 64'(0));
      chk("mid_rst_finsh",  64'(Finsh), 64'(0));
      chk("mid_rst_perr",   64'(Perr), 64'(0));
      chk("mid_rst_beats",  64'(sb.size()), 64'(0));
      for (int i = 0; i < NM; i++) mq[i].delete();
      hq.delete();
      drive();
      @(posedge ACLK);
      #2;
      add_beats(0, 2, 1); expect_beats(0, 2, 1); queue_burst(0, 1); drive();
      @(negedge ACLK);
      ARESET = 1'b0;
      @(posedge ACLK);
      #1;
      chk("first_edge_busy", 64'(Busy), 64'(1));
      wait_done("t_post_rst_timeout");

      chk("fin_outstanding", 64'(exp_fin), 64'(0));
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
